// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store sequencer.
package lsu_pkg;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_store_align.sv
// Byte-enable, lane-shifted write data and misalignment flag for one access.
module lsu_store_align
    import lsu_pkg::*;
(
    input  logic            i_is_st,
    input  logic [2:0]      i_func3,
    input  logic [1:0]      i_off,
    input  logic [31:0]     i_rs2,
    output logic [BE_W-1:0] o_be,
    output logic [31:0]     o_wdata,
    output logic            o_misalign
);

    logic [7:0] w_be_wide;
    logic [4:0] w_sh;

    always_comb begin
        w_be_wide  = 8'h00;
        o_misalign = 1'b0;
        w_sh       = {i_off, 3'b000};
        o_wdata    = 32'h0;
        if (i_is_st) begin
            o_wdata = i_rs2 << w_sh;
            case (i_func3)
                F3_SB: w_be_wide = 8'h01 << i_off;
                F3_SH: begin
                    w_be_wide  = 8'h03 << i_off;
                    o_misalign = (i_off == 2'd3);
                end
                F3_SW: begin
                    w_be_wide  = 8'h0f << i_off;
                    o_misalign = (i_off != 2'd0);
                end
                default: w_be_wide = 8'h00;
            endcase
        end else begin
            // Loads always read the whole word; the filter picks the lane.
            w_be_wide = 8'h0f;
            case (i_func3)
                F3_LH, F3_LHU: o_misalign = (i_off == 2'd3);
                F3_LW:         o_misalign = (i_off != 2'd0);
                default:       o_misalign = 1'b0;
            endcase
        end
        o_be = w_be_wide[BE_W-1:0];
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store sequencer: bus handshake, pipeline stall,
// timeout recovery and raw load capture for the load-data filter.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic              mem_is_st,
    input  logic [2:0]        mem_func3,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              lsu_stall,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BE_W-1:0]   bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata,
    output logic              ld_valid,
    output logic [31:0]       ld_data_raw,
    output logic [2:0]        ld_func3,
    output logic [1:0]        ld_lasttwo,
    output logic              lsu_err,
    output logic              lsu_misalign
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic              r_is_st;
    logic [2:0]        r_func3;
    logic [ADDR_W-1:0] r_addr;
    logic [BE_W-1:0]   r_be;
    logic [31:0]       r_wdata;
    logic              r_mis;
    logic              r_err;
    logic [CW-1:0]     r_cnt;
    logic [31:0]       r_ld_data;
    logic [2:0]        r_ld_func3;
    logic [1:0]        r_ld_lasttwo;

    logic [BE_W-1:0]   w_be;
    logic [31:0]       w_wdata;
    logic              w_mis;
    logic              w_tmo;
    logic              w_cap;
    logic              w_to;

    lsu_store_align u_align (
        .i_is_st    (mem_is_st),
        .i_func3    (mem_func3),
        .i_off      (mem_addr[1:0]),
        .i_rs2      (mem_wdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_misalign (w_mis)
    );

    assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next    = r_state;
        lsu_stall = 1'b0;
        bus_req   = 1'b0;
        w_cap     = 1'b0;
        w_to      = 1'b0;
        case (r_state)
            IDLE: begin
                lsu_stall = mem_valid;
                if (mem_valid) w_next = REQ;
            end
            REQ: begin
                lsu_stall = 1'b1;
                bus_req   = 1'b1;
                if (bus_gnt && bus_rvalid) begin
                    w_next = DONE;
                    w_cap  = 1'b1;
                end else if (w_tmo) begin
                    w_next = DONE;
                    w_to   = 1'b1;
                end else if (bus_gnt) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                lsu_stall = 1'b1;
                if (bus_rvalid) begin
                    w_next = DONE;
                    w_cap  = 1'b1;
                end else if (w_tmo) begin
                    w_next = DONE;
                    w_to   = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_to;
            if (r_state == REQ || r_state == RESP) r_cnt <= r_cnt + 1'b1;
            else                                   r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_st <= 1'b0;
            r_func3 <= 3'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= 32'h0;
            r_mis   <= 1'b0;
        end else if (r_state == IDLE && mem_valid) begin
            r_is_st <= mem_is_st;
            r_func3 <= mem_func3;
            r_addr  <= mem_addr;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_mis   <= w_mis;
        end
    end

    // A timed-out load hands the filter a zero word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_data    <= 32'h0;
            r_ld_func3   <= 3'b0;
            r_ld_lasttwo <= 2'b0;
        end else if ((w_cap || w_to) && !r_is_st) begin
            r_ld_data    <= w_to ? 32'h0 : bus_rdata;
            r_ld_func3   <= r_func3;
            r_ld_lasttwo <= r_addr[1:0];
        end
    end

    assign bus_we       = r_is_st;
    assign bus_addr     = {r_addr[ADDR_W-1:2], 2'b00};
    assign bus_be       = r_be;
    assign bus_wdata    = r_wdata;
    assign ld_valid     = (r_state == DONE) && !r_is_st;
    assign ld_data_raw  = r_ld_data;
    assign ld_func3     = r_ld_func3;
    assign ld_lasttwo   = r_ld_lasttwo;
    assign lsu_err      = (r_state == DONE) && r_err;
    assign lsu_misalign = (r_state == DONE) && r_mis;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with hand-computed expectations.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_is_st;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        lsu_stall;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        ld_valid;
    logic [31:0] ld_data_raw;
    logic [2:0]  ld_func3;
    logic [1:0]  ld_lasttwo;
    logic        lsu_err;
    logic        lsu_misalign;

    int n_chk = 0;
    int n_err = 0;

    int          o_stall;
    int          o_done;
    int          o_ldv;
    logic [31:0] o_raw;
    logic [31:0] o_addr;
    logic [31:0] o_wd;
    logic [3:0]  o_be;
    logic        o_we;
    logic        o_err;
    logic        o_mis;
    logic [1:0]  o_l2;
    logic [2:0]  o_f3;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_valid    (mem_valid),
        .mem_is_st    (mem_is_st),
        .mem_func3    (mem_func3),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .lsu_stall    (lsu_stall),
        .bus_req      (bus_req),
        .bus_gnt      (bus_gnt),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata),
        .ld_valid     (ld_valid),
        .ld_data_raw  (ld_data_raw),
        .ld_func3     (ld_func3),
        .ld_lasttwo   (ld_lasttwo),
        .lsu_err      (lsu_err),
        .lsu_misalign (lsu_misalign)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // gd: REQ cycles without gnt (-1 = never); rd: RESP cycles until
    // rvalid (0 = rvalid together with gnt).
    task automatic run(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input int gd,
                       input int rd);
        int  cyc;
        int  nreq;
        int  nresp;
        bit  granted;
        bit  done;
        o_stall = 0; o_done = 0; o_ldv = 0;
        o_raw = '0; o_addr = '0; o_wd = '0; o_be = '0;
        o_we = 0; o_err = 0; o_mis = 0; o_l2 = '0; o_f3 = '0;
        mem_valid = 1'b1; mem_is_st = st; mem_func3 = f3;
        mem_addr = a; mem_wdata = wd;
        cyc = 1; nreq = 0; nresp = 0; granted = 0; done = 0;
        while (!done && cyc <= 40) begin
            #1;
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
            if (lsu_stall) o_stall++;
            if (bus_req) begin
                o_be = bus_be; o_we = bus_we;
                o_addr = bus_addr; o_wd = bus_wdata;
                if (nreq == gd) begin
                    bus_gnt = 1'b1;
                    granted = 1;
                    if (rd == 0) begin
                        bus_rvalid = 1'b1; bus_rdata = rdat;
                    end
                end
                nreq++;
            end else if (lsu_stall && granted) begin
                nresp++;
                if (nresp == rd) begin
                    bus_rvalid = 1'b1; bus_rdata = rdat;
                end
            end else if (!lsu_stall && cyc > 1) begin
                done = 1;
                o_done = cyc;
                o_ldv += int'(ld_valid);
                o_raw = ld_data_raw; o_err = lsu_err;
                o_mis = lsu_misalign; o_l2 = ld_lasttwo;
                o_f3 = ld_func3;
                mem_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0; mem_valid = 1'b0;
        if (!done) check("done_reached", 32'd0, 32'd1);
        repeat (2) begin
            #1;
            o_ldv += int'(ld_valid);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_valid = 0; mem_is_st = 0; mem_func3 = 0;
        mem_addr = 0; mem_wdata = 0; bus_gnt = 0; bus_rvalid = 0;
        bus_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {31'b0, lsu_stall}, 32'd0);
        check("rst_req",   {31'b0, bus_req},   32'd0);
        check("rst_ldv",   {31'b0, ld_valid},  32'd0);
        check("rst_be",    {28'b0, bus_be},    32'd0);
        check("rst_raw",   ld_data_raw,        32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        check("lw_addr",  o_addr,  32'h100);
        check("lw_done",  o_done,  32'd3);
        check("lw_stall", o_stall, 32'd2);
        check("lw_ldv",   o_ldv,   32'd1);
        check("lw_raw",   o_raw,   32'hDEADBEEF);
        check("lw_l2",    {30'b0, o_l2}, 32'd0);
        check("lw_f3",    {29'b0, o_f3}, 32'd2);
        check("lw_be",    {28'b0, o_be}, 32'hF);

        run(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, -1, 0);
        check("to_done",  o_done,  32'd10);
        check("to_stall", o_stall, 32'd9);
        check("to_err",   {31'b0, o_err}, 32'd1);
        check("to_raw",   o_raw,   32'd0);

        run(1'b0, 3'b000, 32'h203, 32'h0, 32'hA1B2C3D4, 2, 2);
        check("lb_stall", o_stall, 32'd6);
        check("lb_l2",    {30'b0, o_l2}, 32'd3);
        check("lb_f3",    {29'b0, o_f3}, 32'd0);
        check("lb_ldv",   o_ldv,   32'd1);
        check("lb_raw",   o_raw,   32'hA1B2C3D4);
        check("lb_err",   {31'b0, o_err}, 32'd0);
        check("lb_addr",  o_addr,  32'h200);

        run(1'b1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 0, 1);
        check("sh_we",    {31'b0, o_we}, 32'd1);
        check("sh_be",    {28'b0, o_be}, 32'hC);
        check("sh_wd",    o_wd,    32'hABCD0000);
        check("sh_ldv",   o_ldv,   32'd0);
        check("sh_mis",   {31'b0, o_mis}, 32'd0);
        check("sh_hold",  o_raw,   32'hA1B2C3D4);
        check("sh_done",  o_done,  32'd4);

        run(1'b1, 3'b010, 32'h401, 32'hCAFEF00D, 32'h0, 0, 0);
        check("sw_mis",   {31'b0, o_mis}, 32'd1);
        check("sw_be",    {28'b0, o_be}, 32'hE);
        check("sw_wd",    o_wd,    32'hFEF00D00);
        check("sw_addr",  o_addr,  32'h400);
        check("sw_done",  o_done,  32'd3);

        run(1'b1, 3'b000, 32'h102, 32'h11223355, 32'h0, 1, 0);
        check("sb_be",    {28'b0, o_be}, 32'h4);
        check("sb_wd",    o_wd,    32'h33550000);

        run(1'b1, 3'b011, 32'h700, 32'hFFFFFFFF, 32'h0, 0, 0);
        check("bad_be",   {28'b0, o_be}, 32'h0);
        check("bad_done", o_done,  32'd3);

        mem_valid = 1'b1; mem_is_st = 1'b0; mem_func3 = 3'b010;
        mem_addr = 32'h600;
        @(posedge clk);
        #1;
        bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        check("rs_resp",  {31'b0, lsu_stall}, 32'd1);
        rst_n = 1'b0; mem_valid = 1'b0;
        #1;
        check("rs_stall", {31'b0, lsu_stall}, 32'd0);
        check("rs_req",   {31'b0, bus_req},   32'd0);
        check("rs_raw",   ld_data_raw,        32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h55AA55AA;
        o_ldv = 0; o_stall = 0;
        repeat (3) begin
            #1;
            o_ldv += int'(ld_valid);
            o_stall += int'(lsu_stall);
            @(posedge clk);
            #1;
        end
        bus_rvalid = 1'b0;
        check("rs_ldv",   o_ldv,   32'd0);
        check("rs_idle",  o_stall, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
